// File: rtl/div_16x8_seq_pkg.sv
// Shared types and constants for the sequential 2*DW / DW restoring divider.
// Holds the FSM encoding, default operand width and the counter sizing helper.
package div_pkg;

  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Iteration counter must hold the value DW itself, hence the extra bit.
  function automatic int unsigned cnt_width(input int unsigned dw);
    int unsigned w;
    w = $clog2(dw);
    return w + 1;
  endfunction

endpackage

// File: rtl/div_16x8_seq_if.sv
// Operand/result handshake bundle for div_16x8_seq.
// The master issues operands and consumes results; the slave is the divider.
interface div_16x8_seq_if
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] dividend;
  logic [DW-1:0]   divisor;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   quotient;
  logic [DW-1:0]   remainder;
  logic            dz;
  logic            ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dz, ovf
  );

endinterface

// File: rtl/div_16x8_seq_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when the partial remainder allows it.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [DW-1:0] rem,
  input  logic          bin,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_nxt,
  output logic          qbit
);

  logic [DW:0] partial;
  logic [DW:0] trial;

  // rem < divisor on entry keeps {rem,bin} - divisor within DW+1 signed bits.
  assign partial = {rem, bin};
  assign trial   = partial - {1'b0, divisor};
  assign qbit    = ~trial[DW];
  assign rem_nxt = qbit ? trial[DW-1:0] : partial[DW-1:0];

endmodule

// File: rtl/div_16x8_seq.sv
// Sequential restoring divider, one quotient bit per cycle, with valid/ready
// on both sides and early exit for divide-by-zero and quotient overflow.
module div_16x8_seq
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  div_16x8_seq_if.slave  bus
);

  localparam int unsigned CW = cnt_width(DW);

  state_t         state_q, state_d;
  logic [DW-1:0]  rem_q, rem_d;
  logic [DW-1:0]  low_q, low_d;
  logic [DW-1:0]  quot_q, quot_d;
  logic [DW-1:0]  divisor_q, divisor_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dz_q, dz_d;
  logic           ovf_q, ovf_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;

  logic [DW-1:0]  div_hi;
  logic [DW-1:0]  div_lo;
  logic [DW-1:0]  step_rem;
  logic           step_qbit;

  assign div_hi = bus.dividend[2*DW-1:DW];
  assign div_lo = bus.dividend[DW-1:0];

  div_step #(
    .DW (DW)
  ) u_step (
    .rem     (rem_q),
    .bin     (low_q[DW-1]),
    .divisor (divisor_q),
    .rem_nxt (step_rem),
    .qbit    (step_qbit)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      low_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      low_q       <= low_d;
      quot_q      <= quot_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    low_d     = low_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          dz_d      = 1'b0;
          ovf_d     = 1'b0;
          divisor_d = bus.divisor;
          if (bus.divisor == '0) begin
            dz_d    = 1'b1;
            quot_d  = '1;
            rem_d   = div_lo;
            state_d = S_DONE;
          end else if (div_hi >= bus.divisor) begin
            ovf_d   = 1'b1;
            quot_d  = '1;
            rem_d   = div_lo;
            state_d = S_DONE;
          end else begin
            rem_d   = div_hi;
            low_d   = div_lo;
            quot_d  = '0;
            cnt_d   = CW'(DW);
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        rem_d  = step_rem;
        quot_d = {quot_q[DW-2:0], step_qbit};
        low_d  = {low_q[DW-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_div_16x8_seq.sv
// Scoreboard bench for div_16x8_seq: directed cases plus random operands,
// expected results from plain integer division pushed at each acceptance.
module tb_div_16x8_seq;
  import div_pkg::*;

  localparam int unsigned DW = 8;

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    logic          ovf;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rmode = 1'b0;
  logic rval  = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  exp_t exp_q[$];
  exp_t e;

  logic          prev_ov;
  logic          held_v;
  logic [DW-1:0] hq, hr;
  logic          hdz, hovf;

  always #5 clk = ~clk;

  div_16x8_seq_if #(.DW(DW)) bus ();

  div_16x8_seq #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
  endtask

  // Reference: integer division with the saturating dz/ovf conventions.
  function automatic exp_t model(input logic [2*DW-1:0] n, input logic [DW-1:0] d);
    exp_t        r;
    int unsigned ni, di;
    ni = 32'(n);
    di = 32'(d);
    if (di == 0) begin
      r.dz = 1'b1; r.ovf = 1'b0; r.q = '1; r.r = DW'(ni % 256); r.lat = 1;
    end else if (ni / di > 255) begin
      r.dz = 1'b0; r.ovf = 1'b1; r.q = '1; r.r = DW'(ni % 256); r.lat = 1;
    end else begin
      r.dz = 1'b0; r.ovf = 1'b0; r.q = DW'(ni / di); r.r = DW'(ni % di); r.lat = DW + 1;
    end
    return r;
  endfunction

  // Monitor: records acceptances and scores results, latency and hold behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_ov = 1'b0;
      held_v  = 1'b0;
    end else begin
      if (exp_q.size() > 0) check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (held_v) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_quotient", 32'(bus.quotient), 32'(hq));
        check("hold_remainder", 32'(bus.remainder), 32'(hr));
        check("hold_dz", 32'(bus.dz), 32'(hdz));
        check("hold_ovf", 32'(bus.ovf), 32'(hovf));
      end
      held_v = 1'b0;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_no_op", 32'(bus.out_valid), 32'd0);
        end else begin
          if (!prev_ov) check("latency", 32'(cyc - acc_cyc + 1), 32'(exp_q[0].lat));
          if (bus.out_ready) begin
            e = exp_q.pop_front();
            check("quotient", 32'(bus.quotient), 32'(e.q));
            check("remainder", 32'(bus.remainder), 32'(e.r));
            check("dz", 32'(bus.dz), 32'(e.dz));
            check("ovf", 32'(bus.ovf), 32'(e.ovf));
          end else begin
            held_v = 1'b1;
            hq = bus.quotient; hr = bus.remainder; hdz = bus.dz; hovf = bus.ovf;
          end
        end
      end
      prev_ov = bus.out_valid;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.dividend, bus.divisor));
        acc_cyc = cyc + 1;
      end
    end
  end

  // Consumer ready: fixed level or random back-pressure.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rmode ? ($urandom_range(0, 3) != 0) : rval;
    end
  end

  task automatic send(input logic [2*DW-1:0] n, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.dividend = n;
    bus.divisor  = d;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("accept_timeout");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_quotient"}, 32'(bus.quotient), 32'd0);
    check({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
    check({tag, "_dz"}, 32'(bus.dz), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d, hi;
    bit ok;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(16'd15129, 8'd123);
    wait_idle();
    send(16'd65025, 8'd255);
    send(16'd1000, 8'd7);
    wait_idle();
    send(16'd1000, 8'd0);
    wait_idle();
    send(16'h1234, 8'h12);
    send(16'h11FF, 8'h12);
    wait_idle();

    // Back-pressure with stray in_valid while the result is parked.
    rval = 1'b0;
    send(16'd5000, 8'd77);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_timeout("result_timeout");
    @(posedge clk);
    #1;
    bus.dividend = 16'd4321;
    bus.divisor  = 8'd99;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rval = 1'b1;
    wait_idle();

    // Reset during CALC discards the partial result.
    send(16'd1000, 8'd7);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("midop_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd200, 8'd3);
    wait_idle();

    // Random operands with random consumer back-pressure.
    rmode = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      d  = DW'($urandom_range(1, 255));
      hi = DW'($urandom % 32'(d));
      case ($urandom_range(0, 15))
        0:       d  = '0;
        1:       hi = DW'($urandom_range(32'(d), 255));
        default: ;
      endcase
      send({hi, DW'($urandom)}, d);
    end
    rmode = 1'b0;
    rval  = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
